// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and multi-cycle sequencing for the 5-stage MIPS core.
//
// Purpose:
//   - Detects load-use, branch-operand and mul/div-occupancy stalls.
//   - Generates D- and E-stage forwarding selects.
//   - Flushes IF/ID on taken branches and jumps.
//   - Tracks the multi-cycle mul/div unit with a small counter FSM.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   rsD, rtD, rsE, rtE             source register indices (D and E stages)
//   writeRegE/M/W, regWriteE/M/W   destination index and write enable per stage
//   memToRegE/M                    stage holds a load
//   branchD, takenD, jumpD         D-stage control-flow info
//   mdStartE, mdUseD               mul/div issue (E) and HI/LO consumer (D)
//   stallF, stallD, flushD, flushE pipeline register controls
//   forwardAD/BD, forwardAE/BE     forwarding selects (AE/BE: 00 rf, 01 W, 10 M)
//   mdBusy, mdDone                 mul/div running / one-cycle completion pulse
//   stallCnt                       stall-cycle counter
//
// Optional feature: define HAZARD_STATS_EN to build the saturating stall-cycle
// counter. When it is undefined, stallCnt is tied to 0 and no counter flops exist.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rsD,
  input  logic [REG_ADDR_W-1:0] rtD,
  input  logic [REG_ADDR_W-1:0] rsE,
  input  logic [REG_ADDR_W-1:0] rtE,
  input  logic [REG_ADDR_W-1:0] writeRegE,
  input  logic [REG_ADDR_W-1:0] writeRegM,
  input  logic [REG_ADDR_W-1:0] writeRegW,
  input  logic                  regWriteE,
  input  logic                  regWriteM,
  input  logic                  regWriteW,
  input  logic                  memToRegE,
  input  logic                  memToRegM,
  input  logic                  branchD,
  input  logic                  takenD,
  input  logic                  jumpD,
  input  logic                  mdStartE,
  input  logic                  mdUseD,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  flushD,
  output logic                  flushE,
  output logic                  forwardAD,
  output logic                  forwardBD,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
  output logic                  mdBusy,
  output logic                  mdDone,
  output logic [31:0]           stallCnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Register 0 is hard-wired, so it never produces a dependency.
  function automatic logic hit(input logic [REG_ADDR_W-1:0] dst,
                               input logic [REG_ADDR_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  logic lw_stall, br_stall, md_stall, stall;
  logic e_hits_d, m_hits_d;

  assign e_hits_d = hit(writeRegE, rsD) || hit(writeRegE, rtD);
  assign m_hits_d = hit(writeRegM, rsD) || hit(writeRegM, rtD);

  assign lw_stall = memToRegE && regWriteE && e_hits_d;
  // Branches compare in D, so an ALU result still in E or a load in M is not yet usable.
  assign br_stall = branchD && ((regWriteE && e_hits_d) || (memToRegM && m_hits_d));
  // mdStartE counts as busy so a consumer directly behind the issuing op also waits.
  assign md_stall = mdUseD && (mdBusy || mdStartE);
  assign stall    = lw_stall || br_stall || md_stall;

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  // A stalled branch re-evaluates next cycle, so it must not flush yet.
  assign flushD = (takenD || jumpD) && !stall;

  assign forwardAD = regWriteM && hit(writeRegM, rsD);
  assign forwardBD = regWriteM && hit(writeRegM, rtD);

  always_comb begin
    forwardAE = 2'b00;
    if (regWriteM && hit(writeRegM, rsE))      forwardAE = 2'b10;
    else if (regWriteW && hit(writeRegW, rsE)) forwardAE = 2'b01;
  end

  always_comb begin
    forwardBE = 2'b00;
    if (regWriteM && hit(writeRegM, rtE))      forwardBE = 2'b10;
    else if (regWriteW && hit(writeRegW, rtE)) forwardBE = 2'b01;
  end

  // Mul/div occupancy: BUSY lasts MD_LATENCY cycles, DONE lasts one. A start
  // seen in DONE reloads directly so back-to-back ops have no idle gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (mdStartE) begin
          state <= BUSY;
          cnt   <= CNT_LOAD;
        end
        BUSY: if (cnt == '0) state <= DONE;
              else           cnt   <= cnt - CNT_W'(1);
        DONE: if (mdStartE) begin
          state <= BUSY;
          cnt   <= CNT_LOAD;
        end else begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign mdBusy = (state == BUSY);
  assign mdDone = (state == DONE);

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_q;

  // Saturates rather than wraps so a long run never reports a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         stat_q <= '0;
    else if (stallD && stat_q != '1) stat_q <= stat_q + 32'd1;
  end

  assign stallCnt = stat_q;
`else
  assign stallCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (MD_LATENCY=4).
// Stimulus pushes the reference model's expected outputs into a queue; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_hazard_ctrl;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic          regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
  logic          branchD, takenD, jumpD, mdStartE, mdUseD;
  logic          stallF, stallD, flushD, flushE, forwardAD, forwardBD;
  logic [1:0]    forwardAE, forwardBE;
  logic          mdBusy, mdDone;
  logic [31:0]   stallCnt;

  hazard_ctrl #(.REG_ADDR_W(AW), .MD_LATENCY(LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM),
    .branchD(branchD), .takenD(takenD), .jumpD(jumpD),
    .mdStartE(mdStartE), .mdUseD(mdUseD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mdBusy(mdBusy), .mdDone(mdDone), .stallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sF, sD, fD, fE, aD, bD;
    logic [1:0]  aE, bE;
    logic        busy, done;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: remaining busy cycles, completion pulse pending,
  // and the saturating stall count.
  int          busy_left = 0;
  bit          done_m = 1'b0;
  logic [31:0] scnt = '0;

  function automatic bit m(input logic [AW-1:0] d, input logic [AW-1:0] s);
    return (d != 0) && (d == s);
  endfunction

  function automatic logic [1:0] fsel(input logic [AW-1:0] src);
    if (regWriteM && m(writeRegM, src)) return 2'b10;
    if (regWriteW && m(writeRegW, src)) return 2'b01;
    return 2'b00;
  endfunction

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step();
    exp_t e;
    bit busy, lw, br, md, st;
    busy = !rst && (busy_left > 0);
    lw = memToRegE && regWriteE && (m(writeRegE, rsD) || m(writeRegE, rtD));
    br = branchD && ((regWriteE && (m(writeRegE, rsD) || m(writeRegE, rtD))) ||
                     (memToRegM && (m(writeRegM, rsD) || m(writeRegM, rtD))));
    md = mdUseD && (busy || mdStartE);
    st = lw || br || md;
    e.sF = st; e.sD = st; e.fE = st;
    e.fD = (takenD || jumpD) && !st;
    e.aD = regWriteM && m(writeRegM, rsD);
    e.bD = regWriteM && m(writeRegM, rtD);
    e.aE = fsel(rsE);
    e.bE = fsel(rtE);
    e.busy = busy;
    e.done = !rst && done_m;
`ifdef HAZARD_STATS_EN
    e.sc = rst ? 32'd0 : scnt;
`else
    e.sc = 32'd0;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      busy_left = 0; done_m = 1'b0; scnt = '0;
    end else begin
      if (st && scnt != 32'hFFFF_FFFF) scnt = scnt + 32'd1;
      if (busy_left > 0) begin
        busy_left = busy_left - 1;
        done_m = (busy_left == 0);
      end else begin
        done_m = 1'b0;
        if (mdStartE) busy_left = LAT;
      end
    end
    #1;
  endtask

  task automatic clr();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeRegE = '0; writeRegM = '0; writeRegW = '0;
    regWriteE = 0; regWriteM = 0; regWriteW = 0; memToRegE = 0; memToRegM = 0;
    branchD = 0; takenD = 0; jumpD = 0; mdStartE = 0; mdUseD = 0;
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.sF = stallF; a.sD = stallD; a.fD = flushD; a.fE = flushE;
      a.aD = forwardAD; a.bD = forwardBD; a.aE = forwardAE; a.bE = forwardBE;
      a.busy = mdBusy; a.done = mdDone; a.sc = stallCnt;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d t=%0t outputs{sF sD fD fE aD bD aE bE busy done sc}: got %b %b %b %b %b %b %b %b %b %b %h, want %b %b %b %b %b %b %b %b %b %b %h",
                 vectors, $time, a.sF, a.sD, a.fD, a.fE, a.aD, a.bD, a.aE, a.bE, a.busy, a.done, a.sc,
                 e.sF, e.sD, e.fD, e.fE, e.aD, e.bD, e.aE, e.bE, e.busy, e.done, e.sc);
      end
    end
  end

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step(); step();                       // reset state, all inputs 0
    rst = 1'b0;
    step();                               // all zero after reset

    // Load-use, then same with r0 destination.
    memToRegE = 1; regWriteE = 1; writeRegE = 5; rsD = 5; step();
    writeRegE = 0; step();
    clr();

    // Forward priority on rsE, then rtE.
    regWriteM = 1; regWriteW = 1; writeRegM = 3; writeRegW = 3; rsE = 3; step();
    regWriteM = 0; step();
    rtE = 3; regWriteM = 1; step();
    regWriteM = 0; step();
    clr();

    // Branch operand hazard, then resolved taken branch.
    branchD = 1; regWriteE = 1; writeRegE = 7; rtD = 7; takenD = 1; step();
    regWriteE = 0; step();
    memToRegM = 1; writeRegM = 7; step();
    clr();

    // Mul/div with consumer waiting, then back-to-back start in DONE.
    mdUseD = 1; mdStartE = 1; step();
    mdStartE = 0; repeat (4) step();
    mdStartE = 1; step();                 // DONE cycle: restart
    mdStartE = 0; mdUseD = 0; repeat (2) step();
    rst = 1; step();                      // reset mid-BUSY
    rst = 0; repeat (4) step();

    // Mul/div start while busy is ignored.
    mdStartE = 1; repeat (3) step();
    mdStartE = 0; repeat (4) step();
    clr();

    // Ten stall cycles, then saturation.
    memToRegE = 1; regWriteE = 1; writeRegE = 9; rtD = 9;
    repeat (10) step();
`ifdef HAZARD_STATS_EN
    force dut.stat_q = 32'hFFFF_FFFE;
    release dut.stat_q;
    scnt = 32'hFFFF_FFFE;
    repeat (4) step();
`endif
    clr();
    rst = 1; step();
    rst = 0;

    // Randomized traffic, small register range to provoke matches.
    for (int i = 0; i < 2000; i++) begin
      rsD = AW'($urandom_range(0, 7)); rtD = AW'($urandom_range(0, 7));
      rsE = AW'($urandom_range(0, 7)); rtE = AW'($urandom_range(0, 7));
      writeRegE = AW'($urandom_range(0, 7)); writeRegM = AW'($urandom_range(0, 7));
      writeRegW = AW'($urandom_range(0, 7));
      regWriteE = 1'($urandom); regWriteM = 1'($urandom); regWriteW = 1'($urandom);
      memToRegE = 1'($urandom); memToRegM = 1'($urandom);
      branchD = 1'($urandom); takenD = 1'($urandom); jumpD = ($urandom_range(0, 3) == 0);
      mdStartE = ($urandom_range(0, 3) == 0); mdUseD = 1'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 0;
    clr();
    step();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
